// File: rtl/path_sequencer.sv
// path_sequencer: validates a packed back-traced node list and streams it start-to-destination over a valid/ready handshake.
// Optional abort input enabled by defining SEQ_ABORT_EN.
module path_sequencer #(
    parameter int NODE_W    = 5,
    parameter int MAX_NODES = 20,
    parameter int LIST_W    = NODE_W * MAX_NODES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [LIST_W-1:0] node_list,
    input  logic [NODE_W-1:0] st_node,
    input  logic [NODE_W-1:0] end_node,
    output logic [NODE_W-1:0] node_out,
    output logic              node_valid,
    input  logic              node_ready,
    output logic              busy,
    output logic              done,
`ifdef SEQ_ABORT_EN
    input  logic              abort,
`endif
    output logic              err
);

    localparam int IDX_W = (MAX_NODES > 1) ? $clog2(MAX_NODES) : 1;
    localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(MAX_NODES - 1);

    typedef enum logic [2:0] {IDLE, CHECK, SCAN, EMIT, FIN, FAIL} state_t;

    state_t            state;
    logic [LIST_W-1:0] list_q;
    logic [NODE_W-1:0] st_q;
    logic [NODE_W-1:0] end_q;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  last_idx;
    logic [IDX_W-1:0]  idx_inc;
    logic [NODE_W-1:0] cur_slot;
    logic [NODE_W-1:0] next_slot;
    logic              abort_hit;

`ifdef SEQ_ABORT_EN
    assign abort_hit = abort && (state == CHECK || state == SCAN || state == EMIT);
`else
    assign abort_hit = 1'b0;
`endif

    // Saturating increment keeps the part-select in range even at the last slot.
    assign idx_inc   = (idx == LAST_SLOT) ? idx : idx + 1'b1;
    assign cur_slot  = list_q[idx * NODE_W +: NODE_W];
    assign next_slot = list_q[idx_inc * NODE_W +: NODE_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            list_q     <= '0;
            st_q       <= '0;
            end_q      <= '0;
            idx        <= '0;
            last_idx   <= '0;
            node_out   <= '0;
            node_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (abort_hit) begin
                state      <= IDLE;
                idx        <= '0;
                node_valid <= 1'b0;
                busy       <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (load) begin
                            list_q <= node_list;
                            st_q   <= st_node;
                            end_q  <= end_node;
                            busy   <= 1'b1;
                            state  <= CHECK;
                        end
                    end
                    CHECK: begin
                        if (list_q[NODE_W-1:0] != st_q) begin
                            state <= FAIL;
                        end else begin
                            idx   <= '0;
                            state <= SCAN;
                        end
                    end
                    // First match wins, so a repeated destination further up is never reached.
                    SCAN: begin
                        if (cur_slot == end_q) begin
                            last_idx <= idx;
                            idx      <= '0;
                            state    <= EMIT;
                        end else if (idx == LAST_SLOT) begin
                            state <= FAIL;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                    EMIT: begin
                        if (!node_valid) begin
                            node_out   <= cur_slot;
                            node_valid <= 1'b1;
                        end else if (node_ready) begin
                            if (idx == last_idx) begin
                                node_valid <= 1'b0;
                                state      <= FIN;
                            end else begin
                                idx      <= idx_inc;
                                node_out <= next_slot;
                            end
                        end
                    end
                    FIN: begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    FAIL: begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/path_sequencer.md
Name: path_sequencer

Overview:
- Reader-side counterpart to the path decoder. Takes the packed back-traced node list (start node in the least-significant slot, destination further up) and streams node IDs in forward order, start to destination.
- Handshaked output drives the motion/turn controller one waypoint at a time.
- Validates the list (start slot matches, destination found) before emitting anything.

Parameters:
- NODE_W, 5, bits per node ID
- MAX_NODES, 20, slots in packed list
- LIST_W, NODE_W*MAX_NODES (100), packed list width

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- load  in  1  start request; sampled only in IDLE
- node_list  in  LIST_W  packed path; slot k = NODE_W bits starting k*NODE_W above the least-significant bit; slot 0 = start
- st_node  in  NODE_W  expected start node
- end_node  in  NODE_W  expected destination node
- node_out  out  NODE_W  current waypoint
- node_valid  out  1  node_out valid
- node_ready  in  1  consumer accepts node_out
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse after the last node is accepted
- err  out  1  one-cycle pulse on a malformed list
- abort  in  1  present only with SEQ_ABORT_EN

Behaviour:
- Reset (async assert, sync release): state IDLE; node_out=0, node_valid=0, busy=0, done=0, err=0; internal index and last_idx=0.
- Capture: when load=1 in IDLE, register node_list, st_node and end_node, then go to CHECK. load in any other state is ignored.
- States: IDLE, CHECK, SCAN, EMIT, FIN, FAIL.
- CHECK (1 cycle):
  - slot0 != st_node -> FAIL.
  - Otherwise idx=0 -> SCAN.
- SCAN (one cycle per slot):
  - slot[idx]==end_node -> last_idx=idx, idx=0 -> EMIT.
  - Else if idx==MAX_NODES-1 -> FAIL.
  - Else idx++.
  - The first match wins; a later duplicate of end_node is never reached.
- EMIT:
  - node_out=slot[idx], node_valid=1.
  - node_out must stay stable while node_valid=1 and node_ready=0.
  - Transfer occurs on a clock edge where node_valid and node_ready are both 1.
  - On transfer with idx==last_idx: node_valid=0 -> FIN. Otherwise idx++ and node_out takes the next slot in the same edge, so back-to-back transfers run at one per cycle when node_ready is held.
  - node_ready while node_valid=0 has no effect.
- FIN: done=1 for one cycle -> IDLE.
- FAIL: err=1 for one cycle, no node emitted -> IDLE.
- st_node==end_node: CHECK passes, SCAN matches at idx0, exactly one node is emitted.
- Latency: load at edge t -> CHECK at t+1, SCAN t+2..t+2+last_idx -> node_valid high after edge t+3+last_idx.
- Input changes after capture have no effect.
- Reset mid-operation returns to IDLE immediately with all outputs at reset values. No pending done/err.
- idx is sized ceil(log2(MAX_NODES)) bits and never exceeds MAX_NODES-1.

Optional Feature:
- Macro SEQ_ABORT_EN.
- Defined:
  - abort port exists.
  - abort=1 in CHECK, SCAN or EMIT -> next edge goes to IDLE, node_valid=0, done=0, err=0.
  - A transfer coincident with abort is discarded.
  - abort in IDLE, FIN or FAIL is ignored; the done/err pulse still completes.
- Undefined: no abort port; sequence always runs to FIN or FAIL.

Test Plan:
- Path 3->7->12->9 (slots 0..3 = 3,7,12,9, rest 0), st=3, end=9, node_ready=1 -> node_out 3,7,12,9 on four consecutive cycles; done pulse once; err=0; first valid 6 cycles after the load edge.
- Same list, node_ready toggling 1,0,0,1,... -> node_out held stable during stalls; order unchanged; exactly 4 transfers.
- slot0=4, st=3 -> err pulse 2 cycles after load; node_valid never asserted.
- end=31 absent from all 20 slots -> err after 20 SCAN cycles; no output.
- st=end=5, slot0=5 -> single transfer of 5 then done. Separately: load held high during EMIT -> ignored.
- rst_n low during the second transfer -> outputs 0 asynchronously. After release, a new load runs cleanly. With SEQ_ABORT_EN, abort during EMIT -> IDLE, no done.
